// File: rtl/axi_4_pkg.sv
// Shared AXI4 channel structs plus the read-arbiter state type and response codes.
package axi_4_pkg;

  typedef struct packed {
    logic [3:0]  axid;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
  } read_write_address_channel_t;

  typedef struct packed {
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } read_data_channel_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_4_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr_i, wrapping.
module axi_4_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [IDX_W-1:0]       winner_o,
  output logic                   any_req_o
);

  int idx;

  // Scan from the farthest offset down so the nearest requester to ptr_i wins last.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      if (req_i[idx[IDX_W-1:0]]) begin
        winner_o  = idx[IDX_W-1:0];
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_4_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read slave among NUM_MASTERS masters, one burst at a time.
// Define AXI_RD_ARB_BEAT_CHECK_EN to sequence bursts by axlen and flag rlast disagreements.
module axi_4_read_arbiter
  import axi_4_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_MASTERS-1:0]                        m_arvalid,
  output logic [NUM_MASTERS-1:0]                        m_arready,
  input  read_write_address_channel_t [NUM_MASTERS-1:0] m_ar,
  output logic [NUM_MASTERS-1:0]                        m_rvalid,
  input  logic [NUM_MASTERS-1:0]                        m_rready,
  output read_data_channel_t                            m_r,
  output logic                                          s_arvalid,
  input  logic                                          s_arready,
  output read_write_address_channel_t                   s_ar,
  input  logic                                          s_rvalid,
  output logic                                          s_rready,
  input  read_data_channel_t                            s_r,
  output logic [IDX_W-1:0]                              grant_idx,
  output logic                                          busy
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
  ,
  output logic                                          beat_err
`endif
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] grantIdx_q, grantIdx_d;
  logic [IDX_W-1:0] pickWinner;
  logic             anyReq;
  logic             arHs;
  logic             rHs;
  logic             burstEnd;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
  logic [7:0]       beatCnt_q, beatCnt_d;
  logic             beatErr_q, beatErr_d;
  logic             lastMismatch;
`endif

  axi_4_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req_i    (m_arvalid),
    .ptr_i    (rrPtr_q),
    .winner_o (pickWinner),
    .any_req_o(anyReq)
  );

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grantIdx_d = grantIdx_q;
    m_arready  = '0;
    m_rvalid   = '0;
    m_r        = '0;
    s_arvalid  = 1'b0;
    s_ar       = '0;
    s_rready   = 1'b0;
    arHs       = 1'b0;
    rHs        = 1'b0;
    burstEnd   = 1'b0;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    beatCnt_d    = beatCnt_q;
    beatErr_d    = beatErr_q;
    lastMismatch = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          grantIdx_d = pickWinner;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        s_arvalid             = m_arvalid[grantIdx_q];
        s_ar                  = m_ar[grantIdx_q];
        m_arready[grantIdx_q] = s_arready;
        arHs                  = s_arvalid & s_arready;
        if (arHs) begin
          state_d = DATA;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
          beatCnt_d = m_ar[grantIdx_q].axlen;
`endif
        end
      end
      DATA: begin
        m_rvalid[grantIdx_q] = s_rvalid;
        s_rready             = m_rready[grantIdx_q];
        m_r                  = s_r;
        rHs                  = s_rvalid & s_rready;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
        // The counter, not rlast, decides where the burst ends; a disagreeing rlast is reported.
        lastMismatch = s_r.rlast != (beatCnt_q == 8'd0);
        burstEnd     = rHs && (beatCnt_q == 8'd0);
        if (s_rvalid && lastMismatch) begin
          m_r.rresp = AXI_RESP_SLVERR;
        end
        if (rHs) begin
          beatCnt_d = beatCnt_q - 8'd1;
          if (lastMismatch) begin
            beatErr_d = 1'b1;
          end
        end
`else
        burstEnd = rHs & s_r.rlast;
`endif
        if (burstEnd) begin
          state_d = IDLE;
          rrPtr_d = (grantIdx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grantIdx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
      beatCnt_q  <= '0;
      beatErr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grantIdx_q <= grantIdx_d;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
      beatCnt_q  <= beatCnt_d;
      beatErr_q  <= beatErr_d;
`endif
    end
  end

  assign grant_idx = grantIdx_q;
  assign busy      = (state_q != IDLE);
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
  assign beat_err  = beatErr_q;
`endif

endmodule

// File: tb/tb_axi_4_read_arbiter.sv
// Bench for axi_4_read_arbiter with three masters: arbitration table, corner sequences,
// and a randomized run checked against a queue-free abstract ownership model.
module tb_axi_4_read_arbiter;
  import axi_4_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] mArvalid, mArready, mRvalid, mRready;
  read_write_address_channel_t [N-1:0] mAr;
  read_data_channel_t mR, sR;
  read_write_address_channel_t sAr;
  logic sArvalid, sArready, sRvalid, sRready;
  logic [IW-1:0] grantIdx;
  logic busy;
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
  logic beatErr;
`endif

  int checks   = 0;
  int failures = 0;
  int beat;

  typedef struct {
    logic [N-1:0] req;
    int           len;
    int           expGrant;
  } vec_t;
  vec_t vecs[8];

  // Abstract model state for the randomized phase
  int owner, ptr, slaveLen, slaveBeat, clearArv, cand;
  bit addrDone;
  logic [IW-1:0] expGrantV;
  logic [N-1:0] expArready, expRvalid;
  logic expSArv, expSRr, expBusy;
  read_write_address_channel_t expSAr;
  read_data_channel_t expMR;

  axi_4_read_arbiter #(.NUM_MASTERS(N), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_arvalid(mArvalid),
    .m_arready(mArready),
    .m_ar     (mAr),
    .m_rvalid (mRvalid),
    .m_rready (mRready),
    .m_r      (mR),
    .s_arvalid(sArvalid),
    .s_arready(sArready),
    .s_ar     (sAr),
    .s_rvalid (sRvalid),
    .s_rready (sRready),
    .s_r      (sR),
    .grant_idx(grantIdx),
    .busy     (busy)
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    ,
    .beat_err (beatErr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test finished");
    $fatal(1, "[TB] watchdog");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task applyStimulus(input logic [N-1:0] arv, input logic arRdy, input logic rv, input logic [N-1:0] rRdy);
    mArvalid = arv;
    sArready = arRdy;
    sRvalid  = rv;
    mRready  = rRdy;
  endtask

  task resetDut;
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, '0);
    sR = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task setMaster(input int m, input logic [31:0] addr, input int len);
    mAr[m]        = '0;
    mAr[m].axaddr = addr;
    mAr[m].axlen  = 8'(len);
  endtask

  task automatic serveBurst(input int m, input int len, input string tag);
    logic [N-1:0] expV;
    for (int b = 0; b <= len; b++) begin
      sRvalid     = 1'b1;
      sR          = '0;
      sR.rdata    = 32'hA000 + b;
      sR.rlast    = (b == len);
      mRready     = '1;
      @(negedge clk);
      expV    = '0;
      expV[m] = 1'b1;
      checkOutput({tag, "_rvalid"}, mRvalid, expV);
      checkOutput({tag, "_rdata"}, mR.rdata, 32'hA000 + b);
      tick;
    end
    sRvalid = 1'b0;
    sR      = '0;
    mRready = '0;
    @(negedge clk);
    checkOutput({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{3'b011, 3, 0};
    vecs[1] = '{3'b011, 0, 1};
    vecs[2] = '{3'b011, 1, 0};
    vecs[3] = '{3'b100, 2, 2};
    vecs[4] = '{3'b111, 0, 0};
    vecs[5] = '{3'b101, 1, 2};
    vecs[6] = '{3'b110, 3, 1};
    vecs[7] = '{3'b001, 0, 0};

    for (int i = 0; i < N; i++) setMaster(i, 32'h0, 0);
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, '0);
    sR = '0;
    tick;
    tick;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grantIdx, 0);
    checkOutput("rst_valids", {sArvalid, sRready, mArready, mRvalid}, 0);
    checkOutput("rst_payloads", {sAr, mR}, 0);
    rst_n = 1'b1;

    // Arbitration table: every listed requester held, winner served, others withdrawn
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) setMaster(i, 32'h100 * i + k, vecs[k].len);
      mArvalid = vecs[k].req;
      tick;
      @(negedge clk);
      checkOutput("vec_grant", grantIdx, vecs[k].expGrant);
      checkOutput("vec_sarvalid", sArvalid, 1'b1);
      checkOutput("vec_saraddr", sAr.axaddr, 32'h100 * vecs[k].expGrant + k);
      sArready = 1'b1;
      tick;
      sArready = 1'b0;
      mArvalid = '0;
      serveBurst(vecs[k].expGrant, vecs[k].len, "vec");
    end

    // Master 1 arrives during master 0's data phase and waits for rlast
    resetDut;
    setMaster(0, 32'h5000, 3);
    mArvalid = 3'b001;
    tick;
    sArready = 1'b1;
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    setMaster(1, 32'h6000, 0);
    mArvalid[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      sRvalid  = 1'b1;
      sR       = '0;
      sR.rlast = (b == 3);
      mRready  = '1;
      sArready = 1'b1;
      @(negedge clk);
      checkOutput("wait_arready1", mArready[1], 1'b0);
      tick;
    end
    sRvalid  = 1'b0;
    sArready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle_sarvalid", sArvalid, 1'b0);
    tick;
    @(negedge clk);
    checkOutput("b2b_sarvalid", sArvalid, 1'b1);
    checkOutput("b2b_grant", grantIdx, 1);
    checkOutput("b2b_saraddr", sAr.axaddr, 32'h6000);
    sArready = 1'b1;
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    serveBurst(1, 0, "b2b");

    // Address backpressure then rready toggling on the granted master
    setMaster(0, 32'h7000, 3);
    mArvalid = 3'b001;
    tick;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_sarvalid", sArvalid, 1'b1);
      checkOutput("bp_arready_low", mArready, 3'b000);
      tick;
    end
    sArready = 1'b1;
    @(negedge clk);
    checkOutput("bp_arready", mArready, 3'b001);
    checkOutput("bp_grant", grantIdx, 0);
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      sRvalid  = 1'b1;
      sR       = '0;
      sR.rdata = 32'hB000 + beat;
      sR.rlast = (beat == 3);
      mRready  = (c % 2 == 0) ? 3'b001 : 3'b110;
      @(negedge clk);
      checkOutput("bp_srready", sRready, mRready[0]);
      checkOutput("bp_rvalid", mRvalid, 3'b001);
      checkOutput("bp_rdata", mR.rdata, 32'hB000 + beat);
      if (mRready[0]) beat++;
      tick;
    end
    sRvalid = 1'b0;
    sR      = '0;
    mRready = '0;
    checkOutput("bp_beats", beat, 4);
    @(negedge clk);
    checkOutput("bp_idle", busy, 1'b0);

    // Reset during beat 3 of 4, then a fresh request is served
    setMaster(2, 32'h8000, 3);
    mArvalid = 3'b100;
    tick;
    @(negedge clk);
    checkOutput("mid_grant", grantIdx, 2);
    sArready = 1'b1;
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    for (int b = 0; b < 2; b++) begin
      sRvalid  = 1'b1;
      sR       = '0;
      mRready  = '1;
      tick;
    end
    rst_n = 1'b0;
    tick;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_valids", {sArvalid, sRready, mArready, mRvalid}, 0);
    checkOutput("mid_rst_grant", grantIdx, 0);
    rst_n    = 1'b1;
    sRvalid  = 1'b0;
    mRready  = '0;
    mArvalid = 3'b100;
    tick;
    @(negedge clk);
    checkOutput("mid_new_grant", grantIdx, 2);
    checkOutput("mid_new_sarvalid", sArvalid, 1'b1);
    sArready = 1'b1;
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    serveBurst(2, 0, "mid");

`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    // Early rlast on beat 2: flagged SLVERR, sticky error, burst still runs four beats
    resetDut;
    setMaster(0, 32'h9000, 3);
    mArvalid = 3'b001;
    tick;
    sArready = 1'b1;
    tick;
    sArready = 1'b0;
    mArvalid = '0;
    for (int b = 0; b < 4; b++) begin
      sRvalid  = 1'b1;
      sR       = '0;
      sR.rlast = (b == 1) || (b == 3);
      mRready  = '1;
      @(negedge clk);
      checkOutput("bc_rvalid", mRvalid, 3'b001);
      checkOutput("bc_rresp", mR.rresp, (b == 1) ? 2'b10 : 2'b00);
      checkOutput("bc_err", beatErr, (b >= 2) ? 1'b1 : 1'b0);
      tick;
    end
    sRvalid = 1'b0;
    sR      = '0;
    @(negedge clk);
    checkOutput("bc_end_idle", busy, 1'b0);
    checkOutput("bc_err_sticky", beatErr, 1'b1);
`endif

    // Randomized traffic against the abstract ownership model
    resetDut;
    owner     = -1;
    addrDone  = 1'b0;
    ptr       = 0;
    expGrantV = '0;
    clearArv  = -1;
    slaveLen  = 0;
    slaveBeat = 0;
    for (int c = 0; c < 1500; c++) begin
      if (clearArv >= 0) begin
        mArvalid[clearArv] = 1'b0;
        clearArv = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!mArvalid[i] && $urandom_range(0, 3) == 0) begin
          mAr[i].axid    = 4'($urandom);
          mAr[i].axaddr  = $urandom;
          mAr[i].axlen   = 8'($urandom_range(0, 3));
          mAr[i].axsize  = 3'($urandom);
          mAr[i].axburst = 2'($urandom);
          mArvalid[i]    = 1'b1;
        end
      end
      sArready = 1'($urandom_range(0, 1));
      mRready  = N'($urandom);
      sR       = '0;
      sR.rid   = 4'($urandom);
      sR.rdata = $urandom;
      if (owner >= 0 && addrDone) begin
        sRvalid  = ($urandom_range(0, 9) < 7);
        sR.rlast = (slaveBeat == slaveLen);
      end else begin
        sRvalid = 1'b0;
      end
      @(negedge clk);
      expBusy    = (owner >= 0);
      expArready = '0;
      expRvalid  = '0;
      expSArv    = 1'b0;
      expSRr     = 1'b0;
      expSAr     = '0;
      expMR      = '0;
      if (owner >= 0 && !addrDone) begin
        expSArv           = mArvalid[owner];
        expArready[owner] = sArready;
        expSAr            = mAr[owner];
      end
      if (owner >= 0 && addrDone) begin
        expRvalid[owner] = sRvalid;
        expSRr           = mRready[owner];
        expMR            = sR;
      end
      checkOutput("rand_ctrl", {busy, grantIdx, sArvalid, mArready, mRvalid, sRready},
                  {expBusy, expGrantV, expSArv, expArready, expRvalid, expSRr});
      checkOutput("rand_sar", sAr, expSAr);
      checkOutput("rand_mr", mR, expMR);
      if (owner < 0) begin
        for (int o = 0; o < N; o++) begin
          cand = (ptr + o) % N;
          if (mArvalid[cand]) begin
            owner     = cand;
            expGrantV = IW'(cand);
            break;
          end
        end
      end else if (!addrDone) begin
        if (mArvalid[owner] && sArready) begin
          addrDone  = 1'b1;
          slaveLen  = int'(mAr[owner].axlen);
          slaveBeat = 0;
          clearArv  = owner;
        end
      end else if (sRvalid && mRready[owner]) begin
        if (sR.rlast) begin
          ptr      = (owner + 1) % N;
          owner    = -1;
          addrDone = 1'b0;
        end else begin
          slaveBeat++;
        end
      end
      tick;
    end
`ifdef AXI_RD_ARB_BEAT_CHECK_EN
    @(negedge clk);
    checkOutput("rand_beat_err", beatErr, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
